uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
Byte FIFO and launch sequencer that sits directly upstream of the UART sender. Producers push bytes at any rate. The block hands them to the sender one at a time using the sender's transmit/busy handshake, so no byte is issued while a frame is in flight. It adds overflow and handshake-timeout status for debug LEDs.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_W, 4, log2(DEPTH).
BUSY_TIMEOUT, 8, cycles to wait for tx_busy to rise after a launch pulse; at least 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_data  input  8  byte to enqueue.
wr_en  input  1  enqueue strobe; one byte per cycle while high.
full  output  1  FIFO holds DEPTH bytes.
empty  output  1  FIFO holds 0 bytes.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a write is dropped.
timeout_err  output  1  sticky; set when the sender never acknowledged a launch.
clr_status  input  1  synchronous clear of overflow and timeout_err.
tx_data  output  8  byte presented to the sender's data input; held stable from launch until return to IDLE.
tx_start  output  1  one-cycle launch pulse to the sender's transmit input.
tx_busy  input  1  sender busy flag.

Behaviour:
- Reset (rst_n low, asynchronous), values held until release:
  - rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0.
  - overflow=0, timeout_err=0, tx_data=8'h00, tx_start=0.
  - state=IDLE, timer=0.
  - Memory contents are don't-care.
- Reset mid-frame: the queue is discarded and tx_start is forced low. The sender is not aborted.
- Pointers are ADDR_W bits and wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0). Both are combinational from the count register.
- Write accept: wr_en && !full stores wr_data at wr_ptr and increments wr_ptr.
- Write drop: wr_en && full drops the byte and sets overflow. This holds even if a pop occurs in the same cycle.
- Pop occurs only in the IDLE launch (below). Count update:
  - +1 on accepted write only.
  - -1 on pop only.
  - unchanged on both or neither.
- Write and pop in the same cycle on a non-full FIFO are both honoured.
- clr_status clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- FSM:
  - IDLE: if !empty && !tx_busy, then tx_data <= mem[rd_ptr], rd_ptr++, pop, tx_start <= 1, go to START. Otherwise stay.
  - START: tx_start <= 0; timer <= 0; go to WAIT_HI.
  - WAIT_HI:
    - If tx_busy, go to WAIT_LO.
    - Otherwise, if timer == BUSY_TIMEOUT-1, set timeout_err, go to IDLE, and count the byte as consumed (no retry).
    - Otherwise timer++.
  - WAIT_LO: if !tx_busy, go to IDLE.
- tx_start is high for exactly one cycle per popped byte and is never high outside the cycle after an IDLE launch.
- Latency on an idle, empty queue with tx_busy low:
  - Write sampled at edge N.
  - empty falls after edge N.
  - Launch at edge N+1; tx_start is high between edges N+1 and N+2.
- Back-to-back throughput: the next launch needs tx_busy low in IDLE. The minimum gap between tx_start pulses is the sender frame time plus 2 cycles.
- tx_busy already high in IDLE (sender in use elsewhere): the block waits and does not pop.
- A read of an empty FIFO is impossible by construction.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, tx_busy=0 -> all outputs at reset values, tx_start never pulses, empty=1, count=0.
2. Single byte: write 8'hA5 at edge N, model sender raises busy 1 cycle after tx_start for 100 cycles -> tx_start is a one-cycle pulse after edge N+1, tx_data=8'hA5 held through WAIT_LO, count returns to 0, no second pulse.
3. Ordering and wrap: write 20 bytes 8'h00..8'h13 interleaved so occupancy never exceeds 16 -> the sender receives exactly 00..13 in order, the pointers wrap, overflow stays 0.
4. Overflow: hold tx_busy=1, write 17 bytes 8'h10..8'h20 -> count=16, full=1, 8'h20 dropped, overflow=1. Release busy -> 10..1F emitted. clr_status -> overflow=0.
5. Simultaneous write and pop at count=1 -> count stays 1, both bytes later emitted in order.
6. Timeout: tx_busy tied 0 after a write of 8'h3C -> after BUSY_TIMEOUT cycles in WAIT_HI, timeout_err=1, state returns to IDLE, count=0. Assert rst_n low mid-WAIT_LO -> tx_start=0, count=0 immediately.

Source files
------------

// File: rtl/uart_tx_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_tx_queue
//  Description : Byte FIFO plus launch sequencer in front of a UART sender.
//                Producers push bytes at any rate. Bytes are handed to the
//                sender one at a time over a transmit/busy handshake, so no
//                byte is launched while a frame is in flight. Sticky overflow
//                and handshake-timeout flags are provided for debug LEDs.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1         system clock, rising edge
//    rst_n        in   1         asynchronous active-low reset
//    wr_data      in   8         byte to enqueue
//    wr_en        in   1         enqueue strobe, one byte per cycle
//    full         out  1         FIFO holds DEPTH bytes
//    empty        out  1         FIFO holds no bytes
//    count        out  ADDR_W+1  current occupancy, 0..DEPTH
//    overflow     out  1         sticky, a write was dropped
//    timeout_err  out  1         sticky, sender never acknowledged a launch
//    clr_status   in   1         synchronous clear of both sticky flags
//    tx_data      out  8         byte presented to the sender
//    tx_start     out  1         one-cycle launch pulse to the sender
//    tx_busy      in   1         sender busy flag
// ============================================================================
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout_err,
  input  logic              clr_status,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy
);

  // Timer only has to reach BUSY_TIMEOUT-1.
  localparam int                 TMR_W       = $clog2(BUSY_TIMEOUT);
  localparam logic [ADDR_W:0]    c_depth     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    c_cnt_one   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]  c_ptr_one   = ADDR_W'(1);
  localparam logic [TMR_W-1:0]   c_tmr_one   = TMR_W'(1);
  localparam logic [TMR_W-1:0]   c_tmr_last  = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and registers
  // --------------------------------------------------------------------------
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_timeout_err;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic              w_pop;
  logic              w_timeout;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_accept;
  logic              w_wr_drop;

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  // A full FIFO drops the write even if a pop happens in the same cycle;
  // the slot freed by that pop is not reusable until the next cycle.
  assign w_wr_accept = wr_en & ~w_full;
  assign w_wr_drop   = wr_en &  w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Only launch when the sender is idle; a sender already busy with
        // other traffic simply holds us here.
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_timer == c_tmr_last) begin
          // Sender never acknowledged: the byte is treated as consumed,
          // there is no retry.
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + c_tmr_one;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO memory (contents are don't-care after reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, launch outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_ptr_one;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      // Pulse is high only in the cycle following an IDLE launch.
      r_tx_start <= w_pop;
      case ({w_wr_accept, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status flags: a set event in the same cycle beats a clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_status) begin
        r_overflow <= 1'b0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (clr_status) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_queue
//  Description : Self-checking bench for uart_tx_queue. A queue-based model
//                of the FIFO plus a simple sender model drive and predict
//                the block; each scenario task checks its own results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int BUSY_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              wr_en = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              timeout_err;
  logic              clr_status = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .clr_status  (clr_status),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bytes, all accepted bytes, bytes the sender got.
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  bit         exp_ovf = 1'b0;

  // Sender model: 0 = normal (busy 1 cycle after start), 1 = stuck busy,
  // 2 = never busy. frame_len 0 means random 1..5 cycles per frame.
  int         snd_mode    = 0;
  int         frame_len   = 0;
  bit         snd_pending = 1'b0;
  int         busy_left   = 0;
  int         launches    = 0;
  int         bad_start   = 0;
  int         hold_err    = 0;
  bit         prev_start  = 1'b0;
  bit         cur_valid   = 1'b0;
  logic [7:0] cur_byte    = 8'h00;

  // Advance one clock, update model and sender; leaves time at edge+1.
  task automatic tick();
    bit was_full;
    bit busy_before;
    was_full    = (mq.size() == DEPTH);
    busy_before = tx_busy;
    @(posedge clk);
    #1;
    if (tx_start === 1'b1) begin
      launches++;
      if (prev_start || busy_before || mq.size() == 0) bad_start++;
      if (mq.size() != 0) void'(mq.pop_front());
      rx_q.push_back(tx_data);
      cur_byte  = tx_data;
      cur_valid = 1'b1;
    end
    if (wr_en) begin
      if (was_full) exp_ovf = 1'b1;
      else begin
        mq.push_back(wr_data);
        acc_q.push_back(wr_data);
      end
    end
    if (clr_status && !(wr_en && was_full)) exp_ovf = 1'b0;
    prev_start = (tx_start === 1'b1);
    if (cur_valid && tx_busy && snd_mode == 0 && tx_data !== cur_byte) hold_err++;
    if (snd_mode == 2) tx_busy = 1'b0;
    else if (snd_mode == 1) tx_busy = 1'b1;
    else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (snd_pending) begin
        tx_busy     = 1'b1;
        busy_left   = (frame_len > 0) ? frame_len : int'($urandom_range(1, 5));
        snd_pending = 1'b0;
      end
      if (tx_start === 1'b1) snd_pending = 1'b1;
    end
  endtask

  task automatic clear_model();
    mq.delete();
    acc_q.delete();
    rx_q.delete();
    exp_ovf     = 1'b0;
    prev_start  = 1'b0;
    cur_valid   = 1'b0;
    snd_pending = 1'b0;
  endtask

  // Run until queue, sender and block are quiet; ok=0 if it never settles.
  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && !tx_busy && !snd_pending && busy_left == 0 && tx_start !== 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; tx_busy = 1'b0; snd_mode = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
          timeout_err !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_values: count=%0d empty=%b full=%b ovf=%b tmo=%b start=%b data=%h required 0/1/0/0/0/0/00",
                 count, empty, full, overflow, timeout_err, tx_start, tx_data);
      end
    end
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (tx_start !== 1'b0 || empty !== 1'b1 || count !== 0) begin
        failures++;
        $display("FAIL idle_after_reset: start=%b empty=%b count=%0d required 0/1/0", tx_start, empty, count);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_model(); launches = 0; bad_start = 0; hold_err = 0;
    snd_mode = 0; frame_len = 100;
    wr_data = 8'hA5; wr_en = 1'b1;
    tick();                      // edge N
    wr_en = 1'b0;
    checks++;
    if (empty !== 1'b0 || count !== 1 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL single_after_write: empty=%b count=%0d start=%b required 0/1/0", empty, count, tx_start);
    end
    tick();                      // edge N+1
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || count !== 0) begin
      failures++;
      $display("FAIL single_launch: start=%b data=%h count=%0d required 1/a5/0", tx_start, tx_data, count);
    end
    tick();                      // edge N+2
    checks++;
    if (tx_start !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse_width: start=%b required 0", tx_start);
    end
    for (int i = 0; i < 110; i++) tick();
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_drain: settled=0 required 1"); end
    checks++;
    if (launches !== 1 || bad_start !== 0 || hold_err !== 0) begin
      failures++;
      $display("FAIL single_handshake: launches=%0d bad=%0d hold_err=%0d required 1/0/0", launches, bad_start, hold_err);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || count !== 0) begin
      failures++;
      $display("FAIL single_received: n=%0d count=%0d required n=1 byte a5 count=0", rx_q.size(), count);
    end
  endtask

  task automatic test_order_wrap();
    bit ok;
    int n;
    clear_model(); bad_start = 0; hold_err = 0;
    snd_mode = 0; frame_len = 0;
    n = 0;
    for (int g = 0; g < 2000 && n < 20; g++) begin
      wr_en   = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH);
      wr_data = 8'(n);
      if (wr_en) n++;
      tick();
      checks++;
      if (count !== (ADDR_W+1)'(mq.size()) || overflow !== 1'b0 || empty !== (mq.size() == 0)) begin
        failures++;
        $display("FAIL order_occupancy: count=%0d ovf=%b empty=%b required %0d/0/%0d",
                 count, overflow, empty, mq.size(), mq.size() == 0);
      end
    end
    wr_en = 1'b0;
    drain(ok);
    checks++;
    if (!ok || rx_q.size() != 20 || bad_start != 0 || hold_err != 0) begin
      failures++;
      $display("FAIL order_summary: settled=%b received=%0d bad=%0d hold_err=%0d required 1/20/0/0",
               ok, rx_q.size(), bad_start, hold_err);
    end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i)) begin
        failures++;
        $display("FAIL order_byte[%0d]: got %h required %h", i, rx_q[i], 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int l0;
    clear_model(); bad_start = 0;
    snd_mode = 1; tx_busy = 1'b1; frame_len = 0;
    tick(); tick();
    l0 = launches;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 16 || full !== 1'b1 || empty !== 1'b0 || overflow !== 1'b1 || launches != l0) begin
      failures++;
      $display("FAIL overflow_fill: count=%0d full=%b empty=%b ovf=%b launches=%0d required 16/1/0/1/%0d",
               count, full, empty, overflow, launches, l0);
    end
    // Drop and clear in the same cycle: the set must win.
    wr_en = 1'b1; wr_data = 8'h55; clr_status = 1'b1;
    tick();
    wr_en = 1'b0; clr_status = 1'b0;
    checks++;
    if (overflow !== 1'b1 || overflow !== exp_ovf || count !== 16) begin
      failures++;
      $display("FAIL overflow_set_wins: ovf=%b count=%0d required 1/16", overflow, count);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 16) begin
      failures++;
      $display("FAIL overflow_clear: ovf=%b count=%0d required 0/16", overflow, count);
    end
    snd_mode = 0; tx_busy = 1'b0;
    drain(ok);
    checks++;
    if (!ok || rx_q.size() != 16 || count !== 0 || full !== 1'b0 || overflow !== 1'b0 || bad_start != 0) begin
      failures++;
      $display("FAIL overflow_drain: settled=%b received=%0d count=%0d full=%b ovf=%b bad=%0d required 1/16/0/0/0/0",
               ok, rx_q.size(), count, full, overflow, bad_start);
    end
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL overflow_byte[%0d]: got %h required %h", i, rx_q[i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [7:0] x, y;
    clear_model();
    snd_mode = 0; frame_len = 0;
    x = 8'($urandom); y = 8'($urandom);
    wr_en = 1'b1; wr_data = x;
    tick();
    wr_data = y;
    checks++;
    if (count !== 1) begin failures++; $display("FAIL simul_first: count=%0d required 1", count); end
    tick();
    wr_en = 1'b0;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== x || count !== 1) begin
      failures++;
      $display("FAIL simul_both: start=%b data=%h count=%0d required 1/%h/1", tx_start, tx_data, count, x);
    end
    drain(ok);
    checks++;
    if (!ok || rx_q.size() != 2 || rx_q[0] !== x || rx_q[1] !== y) begin
      failures++;
      $display("FAIL simul_order: settled=%b n=%0d required 2 bytes %h %h", ok, rx_q.size(), x, y);
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_model(); bad_start = 0; hold_err = 0;
    snd_mode = 0; frame_len = 0;
    for (int i = 0; i < 300; i++) begin
      wr_en      = ($urandom_range(0, 2) != 0);
      wr_data    = 8'($urandom);
      clr_status = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (count !== (ADDR_W+1)'(mq.size()) || full !== (mq.size() == DEPTH) ||
          empty !== (mq.size() == 0) || overflow !== exp_ovf || timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL random_state cyc %0d: count=%0d full=%b empty=%b ovf=%b tmo=%b required %0d/%0d/%0d/%b/0",
                 i, count, full, empty, overflow, timeout_err, mq.size(), mq.size() == DEPTH, mq.size() == 0, exp_ovf);
      end
    end
    wr_en = 1'b0; clr_status = 1'b0;
    drain(ok);
    checks++;
    if (!ok || rx_q.size() != acc_q.size() || bad_start != 0 || hold_err != 0) begin
      failures++;
      $display("FAIL random_summary: settled=%b received=%0d accepted=%0d bad=%0d hold_err=%0d",
               ok, rx_q.size(), acc_q.size(), bad_start, hold_err);
    end
    for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== acc_q[i]) begin
        failures++;
        $display("FAIL random_byte[%0d]: got %h required %h", i, rx_q[i], acc_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit got;
    int n;
    int l0;
    clear_model();
    snd_mode = 2; tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_start === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || tx_data !== 8'h3C) begin
      failures++;
      $display("FAIL timeout_launch: seen=%b data=%h required 1/3c", got, tx_data);
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != BUSY_TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_latency: cycles=%0d required %0d", n, BUSY_TIMEOUT + 1);
    end
    l0 = launches;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (timeout_err !== 1'b1 || count !== 0 || empty !== 1'b1 || launches != l0) begin
      failures++;
      $display("FAIL timeout_after: tmo=%b count=%0d empty=%b extra_launches=%0d required 1/0/1/0",
               timeout_err, count, empty, launches - l0);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: tmo=%b required 0", timeout_err);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int l0;
    clear_model();
    snd_mode = 0; frame_len = 40;
    wr_en = 1'b1; wr_data = 8'h81;
    tick();
    wr_data = 8'h82;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (tx_busy !== 1'b1 || count !== 1 || tx_data !== 8'h81) begin
      failures++;
      $display("FAIL midframe_setup: busy=%b count=%0d data=%h required 1/1/81", tx_busy, count, tx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || count !== 0 || empty !== 1'b1 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset: start=%b count=%0d empty=%b data=%h required 0/0/1/00",
               tx_start, count, empty, tx_data);
    end
    clear_model();
    tick(); tick();
    rst_n = 1'b1;
    l0 = launches;
    drain(ok);
    checks++;
    if (!ok || launches != l0 || count !== 0) begin
      failures++;
      $display("FAIL midframe_discard: settled=%b launches=%0d count=%0d required 1/0/0", ok, launches - l0, count);
    end
    // Reset landing while the launch pulse is high.
    wr_en = 1'b1; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL pulse_setup: start=%b required 1", tx_start);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || count !== 0) begin
      failures++;
      $display("FAIL pulse_reset: start=%b count=%0d required 0/0", tx_start, count);
    end
    clear_model();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_order_wrap();
    test_overflow();
    test_simultaneous();
    test_random();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
